// File: rtl/l1i_tag_controller.sv
`timescale 1ns/1ps
// l1i_tag_controller
// Sequences the L1 instruction-cache tag-query stage. Owns the single-port tag
// memory command inputs (lookup read / fill write, never both in one cycle),
// classifies each returned tag as hit or miss, and on a miss runs the
// line-request -> tag-fill -> replay sequence.
//
// Ports
//   clock_i, reset_i (async, active low), flushPipeline_i
//   fetch side : fetchReq_i, fetch{Tag,Index,Offset}_i -> fetchReady_o
//   tag query  : tqFetchEnable_o, tq{Tag,Index,Offset}_o (lookup),
//                tqUpdateEnable_o, tqNew{Tag,Index}_o (fill),
//                tqEnable_i, tq{Tag,Index,Offset}_i, tqQueriedTag_i (result)
//   result     : hit_o, miss_o pulses with resIndex_o / resOffset_o
//   memory     : memReq_o / memAddr_o, memAck_i, memDone_i
module l1i_tag_controller #(
    parameter int offsetSize = 5,
    parameter int indexSize  = 8,
    parameter int tagSize    = 64 - (offsetSize + indexSize)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  flushPipeline_i,
    input  logic                  fetchReq_i,
    input  logic [tagSize-1:0]    fetchTag_i,
    input  logic [indexSize-1:0]  fetchIndex_i,
    input  logic [offsetSize-1:0] fetchOffset_i,
    output logic                  fetchReady_o,
    output logic                  tqFetchEnable_o,
    output logic                  tqUpdateEnable_o,
    output logic [tagSize-1:0]    tqTag_o,
    output logic [indexSize-1:0]  tqIndex_o,
    output logic [offsetSize-1:0] tqOffset_o,
    output logic [tagSize-1:0]    tqNewTag_o,
    output logic [indexSize-1:0]  tqNewIndex_o,
    input  logic                  tqEnable_i,
    input  logic [tagSize-1:0]    tqTag_i,
    input  logic [indexSize-1:0]  tqIndex_i,
    input  logic [offsetSize-1:0] tqOffset_i,
    input  logic [tagSize:0]      tqQueriedTag_i,
    output logic                  hit_o,
    output logic                  miss_o,
    output logic [indexSize-1:0]  resIndex_o,
    output logic [offsetSize-1:0] resOffset_o,
    output logic                  memReq_o,
    output logic [63:0]           memAddr_o,
    input  logic                  memAck_i,
    input  logic                  memDone_i
);

    typedef enum logic [2:0] {
        S_LOOKUP, S_MISS_REQ, S_MISS_WAIT, S_FILL, S_REPLAY_ISSUE, S_REPLAY_WAIT
    } state_t;

    state_t                r_state, w_next;
    logic                  r_live;        // 0 until the first edge after reset release
    logic [1:0]            r_inflight;
    logic                  r_skipReplay;  // flush seen after the request was acked
    logic                  r_memReq;
    logic                  r_tqEn;
    logic [tagSize-1:0]    r_tqTag;
    logic [indexSize-1:0]  r_tqIndex;
    logic [offsetSize-1:0] r_tqOffset;
    logic [tagSize-1:0]    r_missTag;
    logic [indexSize-1:0]  r_missIndex;
    logic [offsetSize-1:0] r_missOffset;
    logic                  r_hit, r_miss;
    logic [indexSize-1:0]  r_resIndex;
    logic [offsetSize-1:0] r_resOffset;

    logic w_tagMatch, w_resOk, w_hitPulse, w_missPulse;
    logic w_accept, w_replayIssue, w_fill;

    // Results are only meaningful in LOOKUP and REPLAY_WAIT; elsewhere they
    // belong to squashed fetches. A flush discards the result in flight.
    assign w_tagMatch    = tqQueriedTag_i[0] && (tqQueriedTag_i[tagSize:1] == tqTag_i);
    assign w_resOk       = tqEnable_i && !flushPipeline_i &&
                           (r_state == S_LOOKUP || r_state == S_REPLAY_WAIT);
    assign w_hitPulse    = w_resOk && w_tagMatch;
    assign w_missPulse   = w_resOk && !w_tagMatch;
    assign fetchReady_o  = r_live && (r_state == S_LOOKUP) && !w_missPulse;
    assign w_accept      = fetchReq_i && fetchReady_o;
    assign w_replayIssue = (r_state == S_REPLAY_ISSUE) && !flushPipeline_i && (r_inflight == 2'd0);
    // The fill write waits for outstanding reads so it never races a lookup.
    assign w_fill        = (r_state == S_FILL) && (r_inflight == 2'd0);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_LOOKUP:       if (w_missPulse) w_next = S_MISS_REQ;
            S_MISS_REQ: begin
                if (memAck_i && r_memReq) w_next = S_MISS_WAIT;
                else if (flushPipeline_i) w_next = S_LOOKUP;
            end
            S_MISS_WAIT:    if (memDone_i) w_next = S_FILL;
            S_FILL:         if (w_fill) w_next = (r_skipReplay || flushPipeline_i) ? S_LOOKUP : S_REPLAY_ISSUE;
            S_REPLAY_ISSUE: begin
                if (flushPipeline_i) w_next = S_LOOKUP;
                else if (r_inflight == 2'd0) w_next = S_REPLAY_WAIT;
            end
            S_REPLAY_WAIT: begin
                if (flushPipeline_i) w_next = S_LOOKUP;
                else if (w_hitPulse) w_next = S_LOOKUP;
                else if (w_missPulse) w_next = S_MISS_REQ;
            end
            default:        w_next = S_LOOKUP;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state      <= S_LOOKUP;
            r_live       <= 1'b0;
            r_inflight   <= 2'd0;
            r_skipReplay <= 1'b0;
            r_memReq     <= 1'b0;
            r_tqEn       <= 1'b0;
            r_tqTag      <= '0;
            r_tqIndex    <= '0;
            r_tqOffset   <= '0;
            r_missTag    <= '0;
            r_missIndex  <= '0;
            r_missOffset <= '0;
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
            r_resIndex   <= '0;
            r_resOffset  <= '0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;

            // The tag-query stage is flushed alongside us, so its reads vanish.
            if (flushPipeline_i)
                r_inflight <= 2'd0;
            else if (tqFetchEnable_o && !tqEnable_i)
                r_inflight <= r_inflight + 2'd1;
            else if (!tqFetchEnable_o && tqEnable_i)
                r_inflight <= r_inflight - 2'd1;

            if (r_state == S_MISS_REQ || r_state == S_MISS_WAIT || r_state == S_FILL)
                r_skipReplay <= r_skipReplay | flushPipeline_i;
            else
                r_skipReplay <= 1'b0;

            // Request rises the cycle after entering MISS_REQ (after the miss pulse).
            r_memReq <= (r_state == S_MISS_REQ) && (w_next == S_MISS_REQ);

            if (w_accept) begin
                r_tqEn     <= 1'b1;
                r_tqTag    <= fetchTag_i;
                r_tqIndex  <= fetchIndex_i;
                r_tqOffset <= fetchOffset_i;
            end else if (w_replayIssue) begin
                r_tqEn     <= 1'b1;
                r_tqTag    <= r_missTag;
                r_tqIndex  <= r_missIndex;
                r_tqOffset <= r_missOffset;
            end else begin
                r_tqEn     <= 1'b0;
                r_tqTag    <= '0;
                r_tqIndex  <= '0;
                r_tqOffset <= '0;
            end

            if (w_missPulse) begin
                r_missTag    <= tqTag_i;
                r_missIndex  <= tqIndex_i;
                r_missOffset <= tqOffset_i;
            end

            r_hit  <= w_hitPulse;
            r_miss <= w_missPulse;
            if (w_hitPulse || w_missPulse) begin
                r_resIndex  <= tqIndex_i;
                r_resOffset <= tqOffset_i;
            end
        end
    end

    assign tqFetchEnable_o  = r_tqEn;
    assign tqTag_o          = r_tqTag;
    assign tqIndex_o        = r_tqIndex;
    assign tqOffset_o       = r_tqOffset;
    assign tqUpdateEnable_o = w_fill;
    assign tqNewTag_o       = w_fill ? r_missTag : '0;
    assign tqNewIndex_o     = w_fill ? r_missIndex : '0;
    assign hit_o            = r_hit;
    assign miss_o           = r_miss;
    assign resIndex_o       = r_resIndex;
    assign resOffset_o      = r_resOffset;
    assign memReq_o         = r_memReq;
    assign memAddr_o        = r_memReq ? {r_missTag, r_missIndex, {offsetSize{1'b0}}} : 64'd0;

endmodule
